// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add multiplier for the EX stage: latches operands on a MUL_OP issue,
// stalls the pipeline and iterates one multiplier bit per cycle. Optional macro: MUL_EARLY_TERM_EN.
module alu_mul_sequencer #(
   parameter int          WIDTH  = 32,
   parameter logic [2:0]  MUL_OP = 3'b111
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       ALUCtrl_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               accept;
   logic               last_iter;
   logic [WIDTH-1:0]   acc_upd;
   logic [WIDTH-1:0]   mplier_upd;

   assign accept     = (state_q == IDLE) & start_i & (ALUCtrl_i == MUL_OP) & ~flush_i;
   assign acc_upd    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign mplier_upd = mplier_q >> 1;

`ifdef MUL_EARLY_TERM_EN
   // Stop as soon as no set multiplier bits remain to be consumed.
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) | (mplier_upd == '0);
`else
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = BUSY;
         BUSY: begin
            if (flush_i)        state_d = IDLE;
            else if (last_iter) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (accept) begin
         mcand_d  = data1_i;
         mplier_d = data2_i;
         acc_d    = '0;
         cnt_d    = '0;
      end else if ((state_q == BUSY) && !flush_i) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_upd;
         acc_d    = acc_upd;
         cnt_d    = cnt_q + CNT_W'(1);
         if (last_iter) result_d = acc_upd;
      end
   end

   // Outputs; stall is forced low while reset is held even if a multiply is being offered.
   always_comb begin
      busy_o   = (state_q == BUSY);
      done_o   = (state_q == DONE);
      stall_o  = ~rst_i & (accept | (state_q == BUSY));
      result_o = result_q;
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: directed corner cases plus random multiplies
// checked against a plain-arithmetic product and a latency rule derived from the operands.
module tb_alu_mul_sequencer;

   localparam int         WIDTH  = 32;
   localparam logic [2:0] MUL_OP = 3'b111;

   logic             clk;
   logic             rst;
   logic             start;
   logic [2:0]       alu_ctrl;
   logic             flush;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [WIDTH-1:0] exp_result;

   alu_mul_sequencer #(.WIDTH(WIDTH), .MUL_OP(MUL_OP)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .ALUCtrl_i (alu_ctrl),
      .flush_i   (flush),
      .data1_i   (data1),
      .data2_i   (data2),
      .stall_o   (stall),
      .busy_o    (busy),
      .done_o    (done),
      .result_o  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] full;
      full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      return full[WIDTH-1:0];
   endfunction

   // Number of BUSY cycles a multiply by b takes.
   function automatic int ref_latency(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_TERM_EN
      int hi = 0;
      for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i;
      return hi + 1;
`else
      return (b == '0) ? WIDTH : WIDTH;
`endif
   endfunction

   // Issue one multiply and follow it to its done pulse. start_i stays asserted with junk
   // operands throughout, so any reload or acceptance in BUSY/DONE shows up as an error.
   task automatic run_mul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit flush_in_done);
      int  lat;
      int  busy_cnt;
      int  stall_cnt;
      int  done_k;
      bit  got_done;
      lat = ref_latency(b);
      @(negedge clk);
      start = 1'b1; alu_ctrl = MUL_OP; data1 = a; data2 = b;
      #1 check({tag, ".stall_on_accept"}, WIDTH'(stall), WIDTH'(1));
      @(posedge clk);
      #1 data1 = $urandom; data2 = $urandom;
      busy_cnt = 0; stall_cnt = 1; done_k = 0; got_done = 1'b0;
      for (int k = 1; k <= WIDTH + 4 && !got_done; k++) begin
         @(negedge clk);
         if (stall) stall_cnt++;
         if (busy)  busy_cnt++;
         if (done) begin
            got_done = 1'b1;
            done_k   = k;
         end
      end
      check({tag, ".done_seen"}, WIDTH'(got_done), WIDTH'(1));
      check({tag, ".done_cycle"}, WIDTH'(done_k), WIDTH'(lat + 1));
      check({tag, ".busy_cycles"}, WIDTH'(busy_cnt), WIDTH'(lat));
      check({tag, ".stall_cycles"}, WIDTH'(stall_cnt), WIDTH'(lat + 1));
      exp_result = ref_product(a, b);
      check({tag, ".result"}, result, exp_result);
      if (flush_in_done) begin
         flush = 1'b1;
         #1 check({tag, ".done_with_flush"}, WIDTH'(done), WIDTH'(1));
      end
      start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      check({tag, ".done_one_cycle"}, WIDTH'(done), WIDTH'(0));
      check({tag, ".idle_after_done"}, WIDTH'(busy), WIDTH'(0));
      check({tag, ".result_hold"}, result, exp_result);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      rst = 1'b1; start = 1'b1; alu_ctrl = MUL_OP; flush = 1'b0;
      data1 = 32'd5; data2 = 32'd5;
      #2;
      check("reset.stall", WIDTH'(stall), WIDTH'(0));
      check("reset.busy", WIDTH'(busy), WIDTH'(0));
      check("reset.done", WIDTH'(done), WIDTH'(0));
      check("reset.result", result, '0);
      exp_result = '0;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b0;

      run_mul("mul7x6", 32'd7, 32'd6, 1'b0);
      run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_mul("mul3x5", 32'd3, 32'd5, 1'b0);
      run_mul("mul7x6b", 32'd7, 32'd6, 1'b0);

      // Non-multiply op is left to the combinational ALU.
      @(negedge clk);
      start = 1'b1; alu_ctrl = 3'b010; data1 = 32'd11; data2 = 32'd13;
      #1 check("nonmul.stall", WIDTH'(stall), WIDTH'(0));
      @(negedge clk);
      check("nonmul.busy", WIDTH'(busy), WIDTH'(0));
      check("nonmul.result", result, exp_result);

      // Flush together with start in IDLE blocks the accept.
      alu_ctrl = MUL_OP; flush = 1'b1;
      #1 check("flush_idle.stall", WIDTH'(stall), WIDTH'(0));
      @(negedge clk);
      check("flush_idle.busy", WIDTH'(busy), WIDTH'(0));
      start = 1'b0; flush = 1'b0;

      // Flush at the 10th BUSY cycle: back to IDLE, no done, old result kept.
      @(negedge clk);
      start = 1'b1; data1 = 32'd9; data2 = 32'h8000_0009;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      check("flush_busy.busy_before", WIDTH'(busy), WIDTH'(1));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy.busy_after", WIDTH'(busy), WIDTH'(0));
      check("flush_busy.done", WIDTH'(done), WIDTH'(0));
      begin
         bit saw_done = 1'b0;
         for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
         end
         check("flush_busy.no_done_later", WIDTH'(saw_done), WIDTH'(0));
      end
      check("flush_busy.result", result, exp_result);

      run_mul("flush_done", 32'd123, 32'd456, 1'b1);
      run_mul("zero_mplier", 32'hDEAD_BEEF, 32'd0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         run_mul($sformatf("rand%0d", i), ra, rb, 1'b0);
      end

      // Async reset mid-BUSY clears everything before the next edge.
      @(negedge clk);
      start = 1'b1; alu_ctrl = MUL_OP; data1 = 32'd100; data2 = 32'h8000_0001;
      @(posedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_busy.busy", WIDTH'(busy), WIDTH'(0));
      check("rst_busy.stall", WIDTH'(stall), WIDTH'(0));
      check("rst_busy.done", WIDTH'(done), WIDTH'(0));
      check("rst_busy.result", result, '0);
      exp_result = '0;
      start = 1'b0;
      @(negedge clk); rst = 1'b0;

      run_mul("after_reset", 32'hFFFF_FFFE, 32'd3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
